// File: rtl/instr_fetch.sv
// Instruction fetch unit: sequential PC generator feeding a small fetch queue toward decode.
// Optional macro FETCH_FAULT_CHECK_EN enables misaligned / out-of-range fetch-address faults.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          QDEPTH   = 2,
    parameter int          MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
        $error("instr_fetch: QDEPTH must be a power of two >= 2");
    end
    if (MEM_SIZE < 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_mem_size
        $error("instr_fetch: MEM_SIZE must be a power of two >= 4");
    end

    logic [63:0]      fetch_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [63:0]      pc_q    [QDEPTH];
    logic [31:0]      instr_q [QDEPTH];
    logic             fault_q;
    logic             addr_bad;
    logic             push;
    logic             pop;

    assign imem_addr = fetch_pc;
    assign out_valid = (count != '0);
    assign out_pc    = pc_q[head];
    assign out_instr = instr_q[head];
    assign fault     = fault_q;

    assign pop  = out_valid & out_ready;
    assign push = !redirect && !fault_q && !addr_bad && ((count < FULL) || pop);

`ifdef FETCH_FAULT_CHECK_EN
    logic [64:0] last_byte;

    // Widened so an address near 2^64 cannot wrap past the range check.
    assign last_byte = {1'b0, fetch_pc} + 65'd3;
    assign addr_bad  = (fetch_pc[1:0] != 2'b00) || (last_byte >= 65'(MEM_SIZE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= 1'b0;
        end else if (addr_bad) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign addr_bad = 1'b0;
    assign fault_q  = 1'b0;
`endif

    // Redirect flushes the queue; a coincident pop needs no action since the consumer already took it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 64'd4;
                tail     <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[tail]    <= fetch_pc;
            instr_q[tail] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; the instruction memory returns word index (addr >> 2).
// Expectations for the fault scenarios follow FETCH_FAULT_CHECK_EN as compiled.
module tb_instr_fetch;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign imem_instr = imem_addr[33:2];

    instr_fetch #(
        .RESET_PC(RESET_PC),
        .QDEPTH  (2),
        .MEM_SIZE(1024)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .fault      (fault)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        out_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
        end
        vectors++;
        if (imem_addr !== RESET_PC) begin
            miscompares++;
            $display("[TB] FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC);
        end
        vectors++;
        if (fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_fault: got %b expected 0", fault);
        end
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: valid %b addr %h expected 0 / %h", out_valid, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        reset_n   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * k) || out_instr !== 32'(k)) begin
                miscompares++;
                $display("[TB] FAIL stream_%0d: valid %b pc %h instr %h expected 1 / %h / %h",
                         k, out_valid, out_pc, out_instr, 64'(4 * k), 32'(k));
            end
        end
    endtask

    task automatic test_stall();
        reset_n   = 1'b0;
        out_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL stall_head: valid %b pc %h instr %h expected 1 / 0 / 0", out_valid, out_pc, out_instr);
        end
        vectors++;
        if (imem_addr !== 64'h8) begin
            miscompares++;
            $display("[TB] FAIL stall_fetch_pc: got %h expected 8", imem_addr);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * k)) begin
                miscompares++;
                $display("[TB] FAIL drain_%0d: valid %b pc %h expected 1 / %h", k, out_valid, out_pc, 64'(4 * k));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        int n;
        n = 0;
        while (n < 8 && out_pc !== 64'h10) begin
            tick();
            n++;
        end
        vectors++;
        if (out_pc !== 64'h10 || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL redirect_setup: pc %h valid %b expected 10 / 1", out_pc, out_valid);
        end
        redirect    = 1'b1;
        redirect_pc = 64'h40;
        tick();
        redirect = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== 64'h40) begin
            miscompares++;
            $display("[TB] FAIL redirect_bubble: valid %b addr %h expected 0 / 40", out_valid, imem_addr);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h40 || out_instr !== 32'h10) begin
            miscompares++;
            $display("[TB] FAIL redirect_first: valid %b pc %h instr %h expected 1 / 40 / 10", out_valid, out_pc, out_instr);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h44 || out_instr !== 32'h11) begin
            miscompares++;
            $display("[TB] FAIL redirect_second: valid %b pc %h instr %h expected 1 / 44 / 11", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_misaligned();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h42;
        tick();
        redirect = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || fault !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL misalign_bubble: valid %b fault %b expected 0 / 0", out_valid, fault);
        end
        tick();
`ifdef FETCH_FAULT_CHECK_EN
        vectors++;
        if (fault !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL misalign_fault: fault %b valid %b expected 1 / 0", fault, out_valid);
        end
        tick();
        vectors++;
        if (fault !== 1'b1 || out_valid !== 1'b0 || imem_addr !== 64'h42) begin
            miscompares++;
            $display("[TB] FAIL misalign_hold: fault %b valid %b addr %h expected 1 / 0 / 42", fault, out_valid, imem_addr);
        end
`else
        vectors++;
        if (fault !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h42 || out_instr !== 32'h10) begin
            miscompares++;
            $display("[TB] FAIL misalign_deliver: fault %b valid %b pc %h instr %h expected 0 / 1 / 42 / 10",
                     fault, out_valid, out_pc, out_instr);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h46) begin
            miscompares++;
            $display("[TB] FAIL misalign_next: valid %b pc %h expected 1 / 46", out_valid, out_pc);
        end
`endif
    endtask

    task automatic test_mem_end();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h3F0;
        tick();
        redirect = 1'b0;
        vectors++;
        if (fault !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL end_redirect: fault %b valid %b expected 0 / 0", fault, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_pc !== 64'h3F0 + 64'(4 * i)) begin
                miscompares++;
                $display("[TB] FAIL end_seq_%0d: valid %b pc %h expected 1 / %h", i, out_valid, out_pc, 64'h3F0 + 64'(4 * i));
            end
        end
        tick();
`ifdef FETCH_FAULT_CHECK_EN
        vectors++;
        if (fault !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL end_fault: fault %b valid %b expected 1 / 0", fault, out_valid);
        end
        redirect    = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect = 1'b0;
        vectors++;
        if (fault !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL end_clear: fault %b valid %b expected 0 / 0", fault, out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0) begin
            miscompares++;
            $display("[TB] FAIL end_restart: valid %b pc %h expected 1 / 0", out_valid, out_pc);
        end
`else
        vectors++;
        if (fault !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h400) begin
            miscompares++;
            $display("[TB] FAIL end_nocheck: fault %b valid %b pc %h expected 0 / 1 / 400", fault, out_valid, out_pc);
        end
`endif
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL full_setup: valid %b expected 1", out_valid);
        end
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        tick();
        redirect = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== 64'h100) begin
            miscompares++;
            $display("[TB] FAIL full_flush: valid %b addr %h expected 0 / 100", out_valid, imem_addr);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== 32'h40) begin
            miscompares++;
            $display("[TB] FAIL full_restart: valid %b pc %h instr %h expected 1 / 100 / 40", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== 64'h100 || imem_addr !== 64'h108) begin
            miscompares++;
            $display("[TB] FAIL mid_setup: valid %b pc %h addr %h expected 1 / 100 / 108", out_valid, out_pc, imem_addr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            miscompares++;
            $display("[TB] FAIL mid_async: valid %b addr %h expected 0 / %h", out_valid, imem_addr, RESET_PC);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_held: valid %b expected 0", out_valid);
        end
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC) begin
            miscompares++;
            $display("[TB] FAIL mid_release: valid %b pc %h expected 1 / %h", out_valid, out_pc, RESET_PC);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_pc !== RESET_PC + 64'h4) begin
            miscompares++;
            $display("[TB] FAIL mid_next: valid %b pc %h expected 1 / %h", out_valid, out_pc, RESET_PC + 64'h4);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_mem_end();
        test_redirect_full();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, 64'h0, first fetch address after reset.
REQ-002 Parameter QDEPTH, 2, fetch-queue depth in entries (power of two, >=2).
REQ-003 Parameter MEM_SIZE, 1024, instruction-memory size in bytes (power of two), used only by the fault check.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 imem_addr  out  64  byte address driven to the combinational instruction memory.
REQ-007 imem_instr  in  32  instruction returned for imem_addr in the same cycle.
REQ-008 redirect  in  1  branch/jump taken; flush and restart fetch at redirect_pc.
REQ-009 redirect_pc  in  64  new fetch address, valid when redirect=1.
REQ-010 out_valid  out  1  queue head holds a valid instruction.
REQ-011 out_ready  in  1  decode accepts the head this cycle.
REQ-012 out_instr  out  32  instruction at queue head.
REQ-013 out_pc  out  64  byte address of out_instr.
REQ-014 fault  out  1  sticky fetch-address fault (see Configuration).

Function
REQ-015 imem_addr SHALL equal the fetch_pc register combinationally.
REQ-016 Push condition: no redirect, no fault, and (count<QDEPTH or pop this cycle); on push, {fetch_pc, imem_instr} is written at tail and fetch_pc <= fetch_pc+4.
REQ-017 fetch_pc+4 SHALL wrap modulo 2^64; no saturation.
REQ-018 Pop: out_valid & out_ready at posedge; head advances; pop and push in the same cycle keep count unchanged.
REQ-019 out_valid SHALL be (count!=0); out_instr/out_pc SHALL be the head entry, held stable while out_valid=1 and out_ready=0.
REQ-020 Full queue with out_ready=0: no push, fetch_pc held.
REQ-021 Redirect at posedge: count<=0, fetch_pc<=redirect_pc, fault cleared; any coincident pop completes (consumer keeps it) but nothing is pushed that cycle.
REQ-022 After a redirect edge, out_valid SHALL be 0 for exactly one cycle, then 1 with out_pc=redirect_pc (1-cycle redirect bubble).
REQ-023 Steady state with out_ready=1 throughout: one instruction per cycle, out_pc incrementing by 4.
REQ-024 Queue pointers are log2(QDEPTH) bits and wrap naturally; count is log2(QDEPTH)+1 bits.

Reset
REQ-025 While reset_n=0: fetch_pc=RESET_PC, count=0, head/tail=0, out_valid=0, fault=0, imem_addr=RESET_PC.
REQ-026 Reset asserted mid-operation discards all queued entries immediately (asynchronously).
REQ-027 First push occurs on the first posedge after reset_n deasserts; out_valid=1 from then with out_pc=RESET_PC.

Configuration
REQ-028 Macro FETCH_FAULT_CHECK_EN: when defined, fault is set at a posedge where fetch_pc[1:0]!=0 or fetch_pc+3>=MEM_SIZE, and the no-fault push condition applies.
REQ-029 With FETCH_FAULT_CHECK_EN: once fault=1, no pushes, fetch_pc held, queued entries still drain; cleared only by redirect or reset.
REQ-030 Without FETCH_FAULT_CHECK_EN: fault tied to 0, no address checks, pushes never blocked by address value.

Verification
REQ-031 Reset RESET_PC=0, mem[i]=i, out_ready=1 -> out_pc 0,4,8,... one per cycle, out_instr 0,1,2,...
REQ-032 out_ready=0 for 5 cycles after reset -> count=2, fetch_pc=8, out_pc=0 held; out_ready=1 -> pcs 0,4,8 in order, none lost or duplicated.
REQ-033 redirect=1, redirect_pc=0x40 while head out_pc=0x10 and out_ready=1 -> 0x10 accepted, one bubble cycle, then out_pc=0x40, 0x44.
REQ-034 With FETCH_FAULT_CHECK_EN, MEM_SIZE=1024: sequential fetch to 0x3FC -> 0x3FC delivered, then fault=1, no 0x400 entry; redirect to 0x0 -> fault=0, out_pc=0.
REQ-035 With FETCH_FAULT_CHECK_EN: redirect_pc=0x42 -> fault=1 next cycle, out_valid=0; without the macro, out_pc=0x42 delivered.
REQ-036 reset_n pulsed low mid-stream with count=2 -> out_valid=0 immediately; after release out_pc=RESET_PC.
